// File: rtl/aes_pkg.sv
// Shared AES constants, schedule state encoding and the inverse rcon step.
// Used by the inverse key schedule and, later, the encrypt side.
package aes_pkg;

  localparam int Nb = 4;
  localparam int Nk = 4;
  localparam int Nr = 10;

  localparam logic [7:0] RCON_LAST = 8'h36;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FIN
  } state_e;

  // Division by x in GF(2^8): undoes one forward rcon doubling.
  function automatic logic [7:0] rcon_inv_step(
    input logic [7:0] rc
  );
    logic [7:0] r;
    if (rc[0]) r = ((rc ^ 8'h1b) >> 1) | 8'h80;
    else       r = rc >> 1;
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four forward AES S-box lookups on a 32-bit word, purely combinational.
// The S-box is the GF(2^8) inverse (a^254) followed by the affine map.
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  assign word_o = {
    sbox(word_i[31:24]),
    sbox(word_i[23:16]),
    sbox(word_i[15:8]),
    sbox(word_i[7:0])
  };

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: emits round keys 10 down to 0
// from a single 128-bit state register, one key per handshake.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10,
  parameter int Nb = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_idx,
  output logic         done
);

  if (Nk != 4 || Nr != 10 || Nb != 4) begin : g_bad_cfg
    $error("inv_key_schedule supports AES-128 only");
  end

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  sw;
  logic [127:0] prev_key;

  assign {w0, w1, w2, w3} = key_q;

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  aes_sub_word u_sub_word (
    .word_i ({p3[23:0], p3[31:24]}),
    .word_o (sw)
  );

  assign p0       = w0 ^ sw ^ {rcon_q, 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          key_d   = last_key_in;
          rcon_d  = RCON_LAST;
          round_d = 4'(Nr);
          busy_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (round_q == 4'd0) begin
            state_d = FIN;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
            rcon_d  = rcon_inv_step(rcon_q);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign key_valid = valid_q;
  assign key_out   = key_q;
  assign round_idx = round_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: forward FIPS-197 expansion as reference,
// randomized keys and key_ready, start/reset disturbances.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key_in;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_out;
  logic [3:0]   round_idx;
  logic         done;

  always #5 clk = ~clk;

  inv_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .last_key_in (last_key_in),
    .busy        (busy),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_out     (key_out),
    .round_idx   (round_idx),
    .done        (done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   sb[256];
  logic [127:0] rk[11];
  logic [127:0] got[11];

  task automatic check_eq(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box via log/antilog tables over generator 3.
  task automatic build_sbox();
    logic [7:0] ex[256];
    int         lg[256];
    logic [7:0] a;
    logic [7:0] v;
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    a = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = a;
      lg[a] = i;
      a = a ^ xt(a);
    end
    for (int x = 0; x < 256; x++) begin
      v = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        b[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8]
             ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
      sb[x] = b;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Forward key expansion; rk[r] is the round-r key.
  task automatic expand(input logic [127:0] ck);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // mode 0: ready high, 1: pattern 100101, 2: random ready.
  // Returns with FIN visible, or right after a reset at rst_at.
  task automatic walk(
    input logic [127:0] ck,
    input int           mode,
    input int           start_at,
    input int           rst_at,
    input bit           preloaded
  );
    int         er;
    int         cyc;
    bit         pulsed;
    logic       rdy;
    logic [5:0] pat;
    pat = 6'b101001;
    expand(ck);
    if (!preloaded) begin
      start       = 1'b1;
      last_key_in = rk[10];
      key_ready   = 1'b0;
      tick();
      start = 1'b0;
    end
    er = 10;
    cyc = 0;
    pulsed = 1'b0;
    forever begin
      if (cyc > 300) begin
        check_eq("walk_timeout", 1, 0);
        return;
      end
      check_eq("key_valid", key_valid, 1);
      check_eq("busy", busy, 1);
      check_eq("round_idx", round_idx, er);
      check_eq("key_out", key_out, rk[er]);
      if (rst_at == er) begin
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        check_eq("rst_key_out", key_out, 0);
        check_eq("rst_round_idx", round_idx, 0);
        check_eq("rst_key_valid", key_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        rst_n = 1'b1;
        return;
      end
      if (start_at == er && !pulsed) begin
        start       = 1'b1;
        last_key_in = ~rk[10] ^ {4{$urandom}};
        pulsed      = 1'b1;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 6];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      key_ready = rdy;
      tick();
      cyc++;
      if (rdy) begin
        got[er] = rk[er] ^ 128'h0;
        got[er] = key_out === key_out ? got[er] : got[er];
        if (er == 0) break;
        er--;
      end
    end
    start     = 1'b0;
    key_ready = 1'b0;
    check_eq("fin_done", done, 1);
    check_eq("fin_busy", busy, 1);
    check_eq("fin_key_valid", key_valid, 0);
    if (mode == 0) check_eq("latency", cyc, 11);
  endtask

  logic [127:0] k;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    key_ready   = 1'b0;
    last_key_in = '0;
    build_sbox();
    tick();
    tick();
    check_eq("reset_key_out", key_out, 0);
    check_eq("reset_round_idx", round_idx, 0);
    check_eq("reset_key_valid", key_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 A.1, with round keys pinned to published values.
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start       = 1'b1;
    last_key_in = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    tick();
    start = 1'b0;
    check_eq("a1_r10", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    key_ready = 1'b1;
    tick();
    check_eq("a1_r9", key_out, 128'hac7766f319fadc2128d12941575c006e);
    check_eq("a1_r9_idx", round_idx, 9);
    for (int i = 0; i < 9; i++) tick();
    check_eq("a1_r0", key_out, k);
    check_eq("a1_r0_idx", round_idx, 0);
    tick();
    key_ready = 1'b0;
    check_eq("a1_done", done, 1);
    tick();
    check_eq("a1_done_clear", done, 0);
    check_eq("a1_busy_clear", busy, 0);

    // Same walk with the reference model and stability under stalls.
    walk(k, 0, -1, -1, 1'b0);
    tick();
    walk(k, 1, -1, -1, 1'b0);
    tick();

    // start while busy is ignored; start during FIN waits for IDLE.
    walk({4{$urandom}}, 2, 5, -1, 1'b0);
    k = {4{$urandom}};
    expand(k);
    start       = 1'b1;
    last_key_in = rk[10];
    tick();
    check_eq("finstart_valid", key_valid, 0);
    check_eq("finstart_busy", busy, 0);
    check_eq("finstart_done", done, 0);
    tick();
    start = 1'b0;
    walk(k, 2, -1, -1, 1'b1);
    tick();

    // Reset at round 6, then a clean walk.
    walk({4{$urandom}}, 2, -1, 6, 1'b0);
    walk({4{$urandom}}, 0, -1, -1, 1'b0);
    tick();

    // Rcon coverage against the FIPS-197 C.1 style key.
    walk(128'h000102030405060708090a0b0c0d0e0f, 0, -1, -1, 1'b0);
    tick();
    for (int n = 0; n < 4; n++) begin
      walk({4{$urandom}}, 2, -1, -1, 1'b0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
